// File: rtl/avalon_st_pkg.sv
// Shared constants, state encoding and byte selection for the operand packetizer.
// PKT_GAP_EN (optional macro) inserts a one-cycle bubble between the A and B packets.
package avalon_st_pkg;

    localparam int OP_W = 32;
    localparam logic [7:0] HDR_A = 8'h01;
    localparam logic [7:0] HDR_B = 8'h00;
    localparam int BEATS_PER_PKT = 5;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_PKT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_A,
        GAP,
        SEND_B
    } pkt_state_e;

    // Beat k (1..4) carries operand bytes MSB first.
    function automatic logic [7:0] op_byte(
        input logic [OP_W-1:0] op,
        input logic [2:0]      k
    );
        logic [7:0] b;
        case (k)
            3'd1:    b = op[OP_W-1  -: 8];
            3'd2:    b = op[OP_W-9  -: 8];
            3'd3:    b = op[OP_W-17 -: 8];
            3'd4:    b = op[OP_W-25 -: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/avalon_st_byte_serializer.sv
// Serialises one header byte plus a 32-bit operand as a 5-beat packet.
// Outputs are registered and hold while the sink stalls.
module avalon_st_byte_serializer
    import avalon_st_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst,
    input  logic            load,
    input  logic [7:0]      hdr,
    input  logic [OP_W-1:0] op,
    input  logic            ready_in,
    output logic            valid_out,
    output logic            startofpacket_out,
    output logic            endofpacket_out,
    output logic [7:0]      data_out,
    output logic            done
);

    logic [2:0] beat;
    logic [2:0] beat_nxt;
    logic       hs;
    logic       free;

    assign hs       = valid_out & ready_in;
    assign done     = hs & endofpacket_out;
    assign beat_nxt = beat + 3'd1;
    assign free     = ~valid_out | done;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            data_out          <= 8'h00;
            beat              <= 3'd0;
        end else if (load && free) begin
            valid_out         <= 1'b1;
            startofpacket_out <= 1'b1;
            endofpacket_out   <= 1'b0;
            data_out          <= hdr;
            beat              <= 3'd0;
        end else if (hs) begin
            if (endofpacket_out) begin
                valid_out         <= 1'b0;
                startofpacket_out <= 1'b0;
                endofpacket_out   <= 1'b0;
                data_out          <= 8'h00;
                beat              <= 3'd0;
            end else begin
                data_out        <= op_byte(op, beat_nxt);
                endofpacket_out <= (beat_nxt == LAST_BEAT);
                beat            <= beat_nxt;
            end
        end
    end

endmodule

// File: rtl/avalon_st_operand_packetizer.sv
// Accepts an (A,B) operand pair and emits an A packet then a B packet.
// Define PKT_GAP_EN to insert one idle cycle between the two packets.
module avalon_st_operand_packetizer
    import avalon_st_pkg::*;
#(
    parameter int         SZ    = 32,
    parameter logic [7:0] HDR_A = avalon_st_pkg::HDR_A,
    parameter logic [7:0] HDR_B = avalon_st_pkg::HDR_B
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [SZ-1:0] cmd_a,
    input  logic [SZ-1:0] cmd_b,
    input  logic          ready_in,
    output logic          valid_out,
    output logic          startofpacket_out,
    output logic          endofpacket_out,
    output logic [7:0]    data_out,
    output logic          busy,
    output logic [15:0]   pkt_cnt
);

    pkt_state_e    state;
    logic [SZ-1:0] op_a;
    logic [SZ-1:0] op_b;
    logic [15:0]   pkt_cnt_q;
    logic          load;
    logic [7:0]    hdr;
    logic [SZ-1:0] op_sel;
    logic          done;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign pkt_cnt   = pkt_cnt_q;
    assign op_sel    = (state == SEND_B) ? op_b : op_a;

    // The next packet's header is loaded at the same edge the decision is made.
    always_comb begin
        load = 1'b0;
        hdr  = HDR_B;
        unique case (state)
            IDLE: begin
                load = cmd_valid;
                hdr  = HDR_A;
            end
`ifdef PKT_GAP_EN
            SEND_A: load = 1'b0;
`else
            SEND_A: load = done;
`endif
            GAP:    load = 1'b1;
            SEND_B: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            pkt_cnt_q <= 16'h0000;
        end else begin
            if (done)
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_a  <= cmd_a;
                        op_b  <= cmd_b;
                        state <= SEND_A;
                    end
                end
                SEND_A: begin
`ifdef PKT_GAP_EN
                    if (done) state <= GAP;
`else
                    if (done) state <= SEND_B;
`endif
                end
                GAP:    state <= SEND_B;
                SEND_B: if (done) state <= IDLE;
            endcase
        end
    end

    avalon_st_byte_serializer u_ser (
        .clk_in            (clk_in),
        .rst               (rst),
        .load              (load),
        .hdr               (hdr),
        .op                (op_sel),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .data_out          (data_out),
        .done              (done)
    );

endmodule
